// File: rtl/fog_filt_pkg.sv
// -----------------------------------------------------------------------------
// fog_filt_pkg
//   Shared types and constants for the filter chain (spike rejection in front
//   of the moving-average filter).
//   - srg_state_t : spike_reject_gate tracking state
//   - FOG_DATA_W  : default sample width for the chain
// -----------------------------------------------------------------------------
package fog_filt_pkg;

  localparam int FOG_DATA_W = 32;

  typedef enum logic {SRG_EMPTY, SRG_TRACK} srg_state_t;

endpackage : fog_filt_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with synchronous clear. Clear wins over increment;
//   the count sticks at all-ones and never wraps.
//   Ports:
//     clk   in   1  clock
//     n_rst in   1  asynchronous active-low reset
//     inc   in   1  count up by one (ignored when saturated)
//     clr   in   1  synchronous clear, priority over inc
//     q     out  W  registered count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Counter register: clear first, then saturating increment.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_q <= {W{1'b0}};
    end else if (clr) begin
      r_q <= {W{1'b0}};
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule : sat_counter

// File: rtl/spike_reject_gate.sv
// -----------------------------------------------------------------------------
// spike_reject_gate
//   Outlier rejection ahead of the moving-average filter. On each trig the new
//   sample is compared with the last accepted sample; a jump above thresh is
//   replaced by the last accepted value. After MAX_REJECT consecutive
//   substitutions the next outlier is force-accepted so genuine steps pass.
//   Ports:
//     clk         in   1           clock
//     n_rst       in   1           asynchronous active-low reset
//     trig        in   1           sample strobe
//     din         in   DATA_WIDTH  signed sample, valid with trig
//     thresh      in   DATA_WIDTH  unsigned max jump, 0 = accept everything
//     clr_cnt     in   1           synchronous clear of reject_cnt
//     dout        out  DATA_WIDTH  cleaned sample, held between strobes
//     trig_out    out  1           strobe one cycle after trig
//     reject_flag out  1           dout is a substitution
//     resync      out  1           pulse with trig_out on a forced accept
//     reject_cnt  out  CNT_WIDTH   saturating substitution count
// -----------------------------------------------------------------------------
module spike_reject_gate
  import fog_filt_pkg::*;
#(
  parameter int DATA_WIDTH = FOG_DATA_W,
  parameter int MAX_REJECT = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  trig,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] thresh,
  input  logic                  clr_cnt,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  trig_out,
  output logic                  reject_flag,
  output logic                  resync,
  output logic [CNT_WIDTH-1:0]  reject_cnt
);

  // Run counter is 8 bits because MAX_REJECT is limited to 1..255.
  localparam logic [7:0] LP_MAX_REJECT = 8'(MAX_REJECT);

  srg_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_last_good;
  logic [7:0]            r_run_cnt;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_trig_out;
  logic                  r_reject_flag;
  logic                  r_resync;

  logic [DATA_WIDTH:0]   w_diff;
  logic [DATA_WIDTH:0]   w_mag;
  logic                  w_outlier;
  logic                  w_room;
  logic                  w_inc;

  // Jump detection: one extra bit so |din - last_good| never overflows,
  // e.g. -2^31 against 2^31-1 yields 2^32-1.
  always_comb begin
    w_diff = {din[DATA_WIDTH-1], din} - {r_last_good[DATA_WIDTH-1], r_last_good};
    if (w_diff[DATA_WIDTH]) begin
      w_mag = (~w_diff) + {{DATA_WIDTH{1'b0}}, 1'b1};
    end else begin
      w_mag = w_diff;
    end
    w_outlier = (thresh != {DATA_WIDTH{1'b0}}) && (w_mag > {1'b0, thresh});
    w_room    = (r_run_cnt < LP_MAX_REJECT);
    w_inc     = trig && (r_state == SRG_TRACK) && w_outlier && w_room;
  end

  // Tracking FSM with registered outputs; only a trig advances it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= SRG_EMPTY;
      r_last_good   <= {DATA_WIDTH{1'b0}};
      r_run_cnt     <= 8'd0;
      r_dout        <= {DATA_WIDTH{1'b0}};
      r_trig_out    <= 1'b0;
      r_reject_flag <= 1'b0;
      r_resync      <= 1'b0;
    end else begin
      r_trig_out <= trig;
      r_resync   <= 1'b0;
      if (trig) begin
        case (r_state)
          SRG_EMPTY: begin
            r_dout        <= din;
            r_last_good   <= din;
            r_run_cnt     <= 8'd0;
            r_reject_flag <= 1'b0;
            r_state       <= SRG_TRACK;
          end
          SRG_TRACK: begin
            if (!w_outlier) begin
              r_dout        <= din;
              r_last_good   <= din;
              r_run_cnt     <= 8'd0;
              r_reject_flag <= 1'b0;
            end else if (w_room) begin
              r_dout        <= r_last_good;
              r_reject_flag <= 1'b1;
              r_run_cnt     <= r_run_cnt + 8'd1;
            end else begin
              // Too many outliers in a row: treat it as a real step.
              r_dout        <= din;
              r_last_good   <= din;
              r_run_cnt     <= 8'd0;
              r_reject_flag <= 1'b0;
              r_resync      <= 1'b1;
            end
          end
          default: begin
            r_state       <= SRG_EMPTY;
            r_run_cnt     <= 8'd0;
            r_reject_flag <= 1'b0;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  sat_counter #(
    .W (CNT_WIDTH)
  ) u_reject_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (w_inc),
    .clr   (clr_cnt),
    .q     (reject_cnt)
  );

  assign dout        = r_dout;
  assign trig_out    = r_trig_out;
  assign reject_flag = r_reject_flag;
  assign resync      = r_resync;

endmodule : spike_reject_gate

// File: tb/tb_spike_reject_gate.sv
// -----------------------------------------------------------------------------
// tb_spike_reject_gate
//   Self-checking bench: directed vector table, hand-written multi-cycle
//   sequences and a randomized run against an arithmetic reference model.
//   DUT built with MAX_REJECT=3 and CNT_WIDTH=4 so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_spike_reject_gate;

  localparam int DW   = 32;
  localparam int MAXR = 3;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk;
  logic          n_rst;
  logic          trig;
  logic [DW-1:0] din;
  logic [DW-1:0] thresh;
  logic          clr_cnt;
  logic [DW-1:0] dout;
  logic          trig_out;
  logic          reject_flag;
  logic          resync;
  logic [CW-1:0] reject_cnt;

  int n_vec;
  int n_err;

  // Reference model state
  int m_last;
  bit m_empty;
  int m_run;
  int m_cnt;
  int m_dout;

  spike_reject_gate #(
    .DATA_WIDTH (DW),
    .MAX_REJECT (MAXR),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .trig        (trig),
    .din         (din),
    .thresh      (thresh),
    .clr_cnt     (clr_cnt),
    .dout        (dout),
    .trig_out    (trig_out),
    .reject_flag (reject_flag),
    .resync      (resync),
    .reject_cnt  (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [31:0] din;
    logic [31:0] thr;
    bit          clr;
    logic [31:0] e_dout;
    bit          e_flag;
    bit          e_res;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 0;
    m_empty = 1'b1;
    m_run   = 0;
    m_cnt   = 0;
    m_dout  = 0;
  endtask

  // Spec rules in plain arithmetic: 64-bit magnitude, no encoded state.
  task automatic model_step(input int d, input logic [31:0] thr, input bit clr,
                            output int e_dout, output bit e_flag, output bit e_res);
    longint diff;
    bit     outl;
    bit     sub;
    diff = longint'(d) - longint'(m_last);
    if (diff < 0) diff = -diff;
    outl  = (thr != 32'd0) && (diff > longint'({32'd0, thr}));
    sub   = 1'b0;
    e_res = 1'b0;
    if (m_empty || !outl) begin
      e_dout = d; e_flag = 1'b0; m_last = d; m_run = 0; m_empty = 1'b0;
    end else if (m_run < MAXR) begin
      e_dout = m_last; e_flag = 1'b1; m_run++; sub = 1'b1;
    end else begin
      e_dout = d; e_flag = 1'b0; e_res = 1'b1; m_last = d; m_run = 0;
    end
    if (clr) m_cnt = 0;
    else if (sub && m_cnt < CMAX) m_cnt++;
    m_dout = e_dout;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0; trig = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
  endtask

  // One trig cycle, then compare outputs one cycle later.
  task automatic trig_check(input string nm, input logic [31:0] d, input logic [31:0] thr,
                            input bit clr, input logic [31:0] e_dout, input bit e_flag,
                            input bit e_res, input int e_cnt);
    @(negedge clk);
    trig = 1'b1; din = d; thresh = thr; clr_cnt = clr;
    @(negedge clk);
    trig = 1'b0; clr_cnt = 1'b0;
    chk({nm, ".trig_out"}, 32'(trig_out), 32'd1);
    chk({nm, ".dout"}, dout, e_dout);
    chk({nm, ".flag"}, 32'(reject_flag), 32'(e_flag));
    chk({nm, ".resync"}, 32'(resync), 32'(e_res));
    chk({nm, ".cnt"}, 32'(reject_cnt), 32'(e_cnt));
  endtask

  task automatic model_trig(input string nm, input int d, input logic [31:0] thr, input bit clr);
    int e_d; bit e_f; bit e_r;
    model_step(d, thr, clr, e_d, e_f, e_r);
    trig_check(nm, d, thr, clr, e_d, e_f, e_r, m_cnt);
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle.trig_out", 32'(trig_out), 32'd0);
      chk("idle.resync", 32'(resync), 32'd0);
      chk("idle.dout_hold", dout, m_dout);
    end
  endtask

  function automatic vec_t mk(bit r, logic [31:0] d, logic [31:0] t, bit c,
                              logic [31:0] ed, bit ef, bit er, int ec);
    vec_t v;
    v.rst = r; v.din = d; v.thr = t; v.clr = c;
    v.e_dout = ed; v.e_flag = ef; v.e_res = er; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    int e_d; bit e_f; bit e_r;
    int pick;
    int d;
    logic [31:0] thr;
    n_vec = 0; n_err = 0;
    n_rst = 1'b0; trig = 1'b0; din = 32'd0; thresh = 32'd0; clr_cnt = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst.dout", dout, 32'd0);
    chk("rst.trig_out", 32'(trig_out), 32'd0);
    chk("rst.flag", 32'(reject_flag), 32'd0);
    chk("rst.resync", 32'(resync), 32'd0);
    chk("rst.cnt", 32'(reject_cnt), 32'd0);

    // Directed table: basic accept, substitution, threshold edge, forced
    // resync, extreme magnitudes and counter clear.
    tbl.push_back(mk(1, 32'd500,   32'd100, 0, 32'd500,  0, 0, 0));
    tbl.push_back(mk(0, 32'd550,   32'd100, 0, 32'd550,  0, 0, 0));
    tbl.push_back(mk(0, 32'd10000, 32'd100, 0, 32'd550,  1, 0, 1));
    tbl.push_back(mk(0, 32'd560,   32'd100, 0, 32'd560,  0, 0, 1));
    tbl.push_back(mk(0, 32'd660,   32'd100, 0, 32'd660,  0, 0, 1));
    tbl.push_back(mk(0, 32'd10000, 32'd100, 0, 32'd660,  1, 0, 2));
    tbl.push_back(mk(1, 32'd0,     32'd10,  0, 32'd0,    0, 0, 0));
    tbl.push_back(mk(0, 32'd1000,  32'd10,  0, 32'd0,    1, 0, 1));
    tbl.push_back(mk(0, 32'd1000,  32'd10,  0, 32'd0,    1, 0, 2));
    tbl.push_back(mk(0, 32'd1000,  32'd10,  0, 32'd0,    1, 0, 3));
    tbl.push_back(mk(0, 32'd1000,  32'd10,  0, 32'd1000, 0, 1, 3));
    tbl.push_back(mk(1, 32'h7fffffff, 32'hfffffffe, 0, 32'h7fffffff, 0, 0, 0));
    tbl.push_back(mk(0, 32'h80000000, 32'hfffffffe, 0, 32'h7fffffff, 1, 0, 1));
    tbl.push_back(mk(0, 32'h80000000, 32'hffffffff, 0, 32'h80000000, 0, 0, 1));
    tbl.push_back(mk(0, 32'h7fffffff, 32'd0,        1, 32'h7fffffff, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      model_step(int'(tbl[i].din), tbl[i].thr, tbl[i].clr, e_d, e_f, e_r);
      trig_check($sformatf("tbl%0d", i), tbl[i].din, tbl[i].thr, tbl[i].clr,
                 tbl[i].e_dout, tbl[i].e_flag, tbl[i].e_res, tbl[i].e_cnt);
    end
    idle_check(2);

    // Back-to-back trigs give back-to-back trig_out
    do_reset();
    @(negedge clk);
    trig = 1'b1; din = 32'd42; thresh = 32'd5;
    model_step(42, 32'd5, 1'b0, e_d, e_f, e_r);
    @(negedge clk);
    din = 32'd4200;
    chk("b2b.first_trig", 32'(trig_out), 32'd1);
    chk("b2b.first_dout", dout, 32'd42);
    model_step(4200, 32'd5, 1'b0, e_d, e_f, e_r);
    @(negedge clk);
    trig = 1'b0;
    chk("b2b.second_trig", 32'(trig_out), 32'd1);
    chk("b2b.second_dout", dout, 32'd42);
    chk("b2b.second_flag", 32'(reject_flag), 32'd1);
    idle_check(1);

    // Saturation: 20 substitutions into a 4-bit counter, then clear with a
    // coincident substitution.
    do_reset();
    model_trig("sat.init", 0, 32'd10, 1'b0);
    for (int i = 0; i < 40; i++) begin
      model_trig("sat.run", (i % 2 == 0) ? 1000 : 0, 32'd10, 1'b0);
    end
    chk("sat.saturated", 32'(reject_cnt), 32'd15);
    model_trig("sat.clr_with_sub", 1000, 32'd10, 1'b1);
    chk("sat.cleared", 32'(reject_cnt), 32'd0);

    // Reset in the middle of an outlier run, with trig_out pending
    do_reset();
    model_trig("mid.init", 0, 32'd10, 1'b0);
    model_trig("mid.out1", 1000, 32'd10, 1'b0);
    model_trig("mid.out2", 1000, 32'd10, 1'b0);
    @(negedge clk);
    trig = 1'b1; din = 32'd1000;
    @(negedge clk);
    trig = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("mid.rst_dout", dout, 32'd0);
    chk("mid.rst_trig_out", 32'(trig_out), 32'd0);
    chk("mid.rst_flag", 32'(reject_flag), 32'd0);
    chk("mid.rst_resync", 32'(resync), 32'd0);
    chk("mid.rst_cnt", 32'(reject_cnt), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    trig_check("mid.after", 32'd9999, 32'd10, 1'b0, 32'd9999, 1'b0, 1'b0, 0);
    model_step(9999, 32'd10, 1'b0, e_d, e_f, e_r);

    // Bypass: thresh=0 passes everything including the extremes
    do_reset();
    for (int i = 0; i < 40; i++) begin
      pick = int'($urandom_range(0, 3));
      case (pick)
        0:       d = int'(32'h80000000);
        1:       d = int'(32'h7fffffff);
        default: d = int'($urandom);
      endcase
      model_trig("bypass", d, 32'd0, 1'b0);
      chk("bypass.dout_eq_din", dout, 32'(d));
      chk("bypass.cnt_zero", 32'(reject_cnt), 32'd0);
    end

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      pick = int'($urandom_range(0, 9));
      case (pick)
        0:       d = int'(32'h80000000);
        1:       d = int'(32'h7fffffff);
        2, 3:    d = int'($urandom);
        default: d = m_last + int'($urandom_range(0, 400)) - 200;
      endcase
      pick = int'($urandom_range(0, 4));
      case (pick)
        0:       thr = 32'd0;
        1:       thr = 32'd50;
        2:       thr = 32'd150;
        3:       thr = 32'hffffffff;
        default: thr = $urandom_range(1, 300);
      endcase
      model_trig("rand", d, thr, ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 2) == 0) idle_check(int'($urandom_range(1, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_spike_reject_gate
